// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared constants for the execute stage
//
// Purpose: ALU opcode encoding, condition-code bit positions, flag-update
// masks and the pipeline bubble values used by exec_stage and alu.
// Ports: none (package).

package exec_pkg;

    // ALU opcodes (4 bit); 13..15 are unassigned and behave as NOP.
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_INC  = 4'd6;
    localparam logic [3:0] OP_DEC  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_MOV  = 4'd10;
    localparam logic [3:0] OP_SETC = 4'd11;
    localparam logic [3:0] OP_CLRC = 4'd12;

    // CCR layout {V,C,N,Z}
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // Which CCR bits an operation is allowed to write
    localparam logic [3:0] MASK_NONE = 4'b0000;
    localparam logic [3:0] MASK_ZN   = 4'b0011;
    localparam logic [3:0] MASK_ZNC  = 4'b0111;
    localparam logic [3:0] MASK_ALL  = 4'b1111;
    localparam logic [3:0] MASK_C    = 4'b0100;

    // Bubble values loaded into the pass-through control fields on flush
    localparam logic [3:0] WB_BUBBLE  = 4'b0000;
    localparam logic [5:0] MEM_BUBBLE = 6'b000000;

endpackage

// File: rtl/exec_stage_alu.sv
// rtl/exec_stage_alu.sv - combinational ALU with flag generation
//
// Purpose: computes the result, the candidate next flags and the mask of
// flags the operation is allowed to change.
// Ports:
//   opA, opB   in  DW  operands
//   aluOp      in  4   opcode (exec_pkg encoding)
//   carryIn    in  1   current C flag, kept by zero-length shifts
//   result     out DW  ALU result
//   nextFlags  out 4   candidate {V,C,N,Z}
//   flagMask   out 4   1 = this flag is written by the operation

module alu
    import exec_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] opA,
    input  logic [DW-1:0] opB,
    input  logic [3:0]    aluOp,
    input  logic          carryIn,
    output logic [DW-1:0] result,
    output logic [3:0]    nextFlags,
    output logic [3:0]    flagMask
);

    localparam logic [DW-1:0] ONE = DW'(1);

    logic [DW:0]   wide;
    logic [DW-1:0] operand;
    logic [3:0]    shamt;
    logic          carry;
    logic          overflow;

    always_comb begin
        result   = opA;
        flagMask = MASK_NONE;
        wide     = '0;
        operand  = opB;
        shamt    = opB[3:0];
        carry    = carryIn;
        overflow = 1'b0;

        case (aluOp)
            OP_ADD, OP_INC: begin
                operand  = (aluOp == OP_INC) ? ONE : opB;
                wide     = {1'b0, opA} + {1'b0, operand};
                result   = wide[DW-1:0];
                carry    = wide[DW];
                overflow = (opA[DW-1] == operand[DW-1]) && (result[DW-1] != opA[DW-1]);
                flagMask = MASK_ALL;
            end
            OP_SUB, OP_DEC: begin
                operand  = (aluOp == OP_DEC) ? ONE : opB;
                result   = opA - operand;
                carry    = opA < operand;  // borrow
                overflow = (opA[DW-1] != operand[DW-1]) && (result[DW-1] != opA[DW-1]);
                flagMask = MASK_ALL;
            end
            OP_AND: begin
                result   = opA & opB;
                flagMask = MASK_ZN;
            end
            OP_OR: begin
                result   = opA | opB;
                flagMask = MASK_ZN;
            end
            OP_NOT: begin
                result   = ~opA;
                flagMask = MASK_ZN;
            end
            OP_SHL: begin
                // Bit DW of the widened value is the last bit pushed out of the MSB.
                wide     = {1'b0, opA} << shamt;
                result   = wide[DW-1:0];
                carry    = (shamt == 4'd0) ? carryIn : wide[DW];
                flagMask = MASK_ZNC;
            end
            OP_SHR: begin
                // Bit 0 of the widened value is the last bit pushed out of the LSB.
                wide     = {opA, 1'b0} >> shamt;
                result   = wide[DW:1];
                carry    = (shamt == 4'd0) ? carryIn : wide[0];
                flagMask = MASK_ZNC;
            end
            OP_MOV: begin
                result = opB;
            end
            OP_SETC: begin
                carry    = 1'b1;
                flagMask = MASK_C;
            end
            OP_CLRC: begin
                carry    = 1'b0;
                flagMask = MASK_C;
            end
            default: begin
            end
        endcase

        nextFlags         = 4'b0000;
        nextFlags[FLAG_Z] = (result == '0);
        nextFlags[FLAG_N] = result[DW-1];
        nextFlags[FLAG_C] = carry;
        nextFlags[FLAG_V] = overflow;
    end

endmodule

// File: rtl/exec_stage.sv
// rtl/exec_stage.sv - pipeline execute stage with forwarding and CCR
//
// Purpose: forwards operands, runs the ALU, maintains the CCR and its
// interrupt shadow, and registers results into the ALU/memory register.
// Ports:
//   clk, rst                      clock, async active-low reset
//   i_enable, i_flush             advance / insert bubble (flush wins)
//   i_WB, i_Mem, i_pc, i_Rdst     pass-through control
//   i_alu_op, i_src_imm, i_immd   operation and operand-B select
//   i_chg_flag                    allow CCR update
//   i_Rsrc1/2, i_read_data1/2     source indices and register-file data
//   i_fwd_{mem,wb}_{en,rdst,data} forwarding sources (mem has priority)
//   i_flag_save/restore(_val)     shadow copy / CCR reload
//   o_*                           registered results, CCR and shadow

module exec_stage
    import exec_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_enable,
    input  logic          i_flush,
    input  logic [3:0]    i_WB,
    input  logic [5:0]    i_Mem,
    input  logic [3:0]    i_alu_op,
    input  logic          i_src_imm,
    input  logic          i_chg_flag,
    input  logic [AW-1:0] i_pc,
    input  logic [2:0]    i_Rdst,
    input  logic [2:0]    i_Rsrc1,
    input  logic [2:0]    i_Rsrc2,
    input  logic [DW-1:0] i_immd,
    input  logic [DW-1:0] i_read_data1,
    input  logic [DW-1:0] i_read_data2,
    input  logic          i_fwd_mem_en,
    input  logic          i_fwd_wb_en,
    input  logic [2:0]    i_fwd_mem_rdst,
    input  logic [2:0]    i_fwd_wb_rdst,
    input  logic [DW-1:0] i_fwd_mem_data,
    input  logic [DW-1:0] i_fwd_wb_data,
    input  logic          i_flag_save,
    input  logic          i_flag_restore,
    input  logic [3:0]    i_flag_restore_val,
    output logic [3:0]    o_WB,
    output logic [5:0]    o_Mem,
    output logic [AW-1:0] o_pc,
    output logic [2:0]    o_Rdst,
    output logic [DW-1:0] o_alu,
    output logic [DW-1:0] o_read_data1,
    output logic [3:0]    o_flag,
    output logic [3:0]    o_saved_flag
);

    logic [DW-1:0] srcA;
    logic [DW-1:0] srcB;
    logic [DW-1:0] operandB;
    logic [DW-1:0] aluResult;
    logic [3:0]    aluFlags;
    logic [3:0]    aluMask;
    logic [3:0]    ccr;
    logic [3:0]    shadow;

    // The younger instruction (memory stage) holds the newer value, so it wins.
    always_comb begin
        srcA = i_read_data1;
        if (i_fwd_mem_en && (i_fwd_mem_rdst == i_Rsrc1)) begin
            srcA = i_fwd_mem_data;
        end else if (i_fwd_wb_en && (i_fwd_wb_rdst == i_Rsrc1)) begin
            srcA = i_fwd_wb_data;
        end

        srcB = i_read_data2;
        if (i_fwd_mem_en && (i_fwd_mem_rdst == i_Rsrc2)) begin
            srcB = i_fwd_mem_data;
        end else if (i_fwd_wb_en && (i_fwd_wb_rdst == i_Rsrc2)) begin
            srcB = i_fwd_wb_data;
        end

        operandB = i_src_imm ? i_immd : srcB;
    end

    alu #(.DW(DW)) aluInst (
        .opA       (srcA),
        .opB       (operandB),
        .aluOp     (i_alu_op),
        .carryIn   (ccr[FLAG_C]),
        .result    (aluResult),
        .nextFlags (aluFlags),
        .flagMask  (aluMask)
    );

    // ALU/memory pipeline register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_WB         <= WB_BUBBLE;
            o_Mem        <= MEM_BUBBLE;
            o_pc         <= '0;
            o_Rdst       <= '0;
            o_alu        <= '0;
            o_read_data1 <= '0;
        end else if (i_flush) begin
            o_WB         <= WB_BUBBLE;
            o_Mem        <= MEM_BUBBLE;
            o_pc         <= '0;
            o_Rdst       <= '0;
            o_alu        <= '0;
            o_read_data1 <= '0;
        end else if (i_enable) begin
            o_WB         <= i_WB;
            o_Mem        <= i_Mem;
            o_pc         <= i_pc;
            o_Rdst       <= i_Rdst;
            o_alu        <= aluResult;
            o_read_data1 <= srcA;
        end
    end

    // CCR: restore ignores stall and flush; ALU writes only the masked bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ccr <= 4'b0000;
        end else if (i_flag_restore) begin
            ccr <= i_flag_restore_val;
        end else if (!i_flush && i_enable && i_chg_flag) begin
            ccr <= (ccr & ~aluMask) | (aluFlags & aluMask);
        end
    end

    // Shadow samples the pre-edge CCR, so a same-edge CCR write does not leak in.
    // A stalled stage keeps its shadow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= 4'b0000;
        end else if (i_flag_save && i_enable) begin
            shadow <= ccr;
        end
    end

    assign o_flag       = ccr;
    assign o_saved_flag = shadow;

endmodule

// File: doc/exec_stage.md
# exec_stage

Execute stage of the 5-stage 16-bit pipeline, sitting between the decode/ALU buffer and the memory stage. Resolves operand forwarding, performs the ALU operation, maintains the condition-code register (CCR) with an interrupt shadow copy, and registers all results into the ALU/memory pipeline register. Output timing is one cycle, with stall and flush control.

## Interface
Parameters:
- DW, 16, datapath width
- AW, 32, PC width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- i_enable  in  1  1 = advance; 0 = hold all registers (stall)
- i_flush  in  1  load a bubble
- i_WB  in  4  write-back control, passed through
- i_Mem  in  6  memory control, passed through
- i_alu_op  in  4  ALU operation (exec_pkg encoding)
- i_src_imm  in  1  operand B = i_immd instead of register
- i_chg_flag  in  1  allow CCR update
- i_pc  in  AW  instruction PC, passed through
- i_Rdst, i_Rsrc1, i_Rsrc2  in  3 each  register indices
- i_immd  in  DW  immediate
- i_read_data1, i_read_data2  in  DW  register-file operands
- i_fwd_mem_en, i_fwd_wb_en  in  1 each  forwarding-source valid
- i_fwd_mem_rdst, i_fwd_wb_rdst  in  3 each  forwarding destination
- i_fwd_mem_data, i_fwd_wb_data  in  DW each  forwarding data
- i_flag_save  in  1  copy CCR to shadow (interrupt entry)
- i_flag_restore  in  1  load CCR from i_flag_restore_val (RTI)
- i_flag_restore_val  in  4  restored flags
- o_WB  out  4  registered pass-through
- o_Mem  out  6  registered pass-through
- o_pc  out  AW  registered pass-through
- o_Rdst  out  3  registered pass-through
- o_alu  out  DW  registered ALU result
- o_read_data1  out  DW  registered forwarded source 1 (store data)
- o_flag  out  4  CCR {V,C,N,Z} = [3:0]
- o_saved_flag  out  4  shadow CCR

## Operation
- Forwarding for each source: the memory forward wins if its enable is set and its rdst matches the source index. Otherwise the WB forward wins on a match. Otherwise the register-file value is used. Forwarding from r0 is not special.
- Operand A is the forwarded src1.
- Operand B is i_immd if i_src_imm is set, else the forwarded src2.
- Opcodes:
  - 0 NOP: result = A, no flags
  - 1 ADD, 2 SUB: result A+B, A−B
  - 3 AND, 4 OR
  - 5 NOT: result ~A
  - 6 INC, 7 DEC: A+1, A−1
  - 8 SHL, 9 SHR: shift A by B[3:0], logical
  - 10 MOV: result = B, no flags
  - 11 SETC, 12 CLRC: result = A
  - 13–15: behave as NOP
- Flag rules. All arithmetic is modulo 2^16.
  - Z = (result == 0); N = result[15].
  - ADD and INC: C = carry out of bit 15; V = signed overflow.
  - SUB and DEC: C = borrow (A < B unsigned); V = signed overflow.
  - AND, OR, NOT: update Z and N only.
  - SHL: C = last bit shifted out of bit 15. SHR: C = last bit shifted out of bit 0. Both update Z and N. A shift amount of 0 leaves C unchanged.
  - SETC and CLRC: write C only.
- CCR write priority: reset, then restore, then flush, then ALU update. ALU update requires i_enable, i_chg_flag and a flag-affecting op.
- i_flag_restore acts even when i_enable = 0 or i_flush = 1.
- Shadow register: written on i_flag_save with the CCR value from before the edge. This holds even when the same edge also updates the CCR.
- Flush: o_WB and o_Mem = 0; o_alu, o_pc, o_Rdst and o_read_data1 = 0. No CCR ALU update. Flush overrides stall.

## Timing
- All outputs are registered. Latency is 1 cycle from inputs to outputs.
- Forwarding and ALU logic is combinational within the cycle.
- Asynchronous reset (rst = 0) clears every output, the CCR and the shadow to 0 immediately, including mid-stall.
- Stall (i_enable = 0, no flush): every output register, the CCR and the shadow hold. The exception is restore, which still loads the CCR.
- Release from reset is synchronous to the first rising edge after rst goes high.
- Simultaneous save and restore: the shadow takes the old CCR and the CCR takes the restore value.

## Structure
- Shared package exec_pkg holds:
  - ALU opcode localparams, 4 bit
  - Flag bit indices FLAG_Z = 0, FLAG_N = 1, FLAG_C = 2, FLAG_V = 3
  - Bubble constants
- One sub-module, alu, which is purely combinational. It takes A, B, op and the current C, and returns result, next flags and a flags-affected mask.
- exec_stage instantiates alu and owns the forwarding muxes, the output register, the CCR and the shadow.

## Test plan
- ADD with read_data1 = 0x7FFF, read_data2 = 0x0001, chg_flag = 1 → next cycle o_alu = 0x8000 and o_flag = V1 C0 N1 Z0.
- SUB of 0x0003 − 0x0005 → o_alu = 0xFFFE, C = 1, N = 1. The same SUB with chg_flag = 0 → CCR unchanged.
- Forward priority: Rsrc1 = 2, both forward sources rdst = 2 (mem data 0x1111, wb data 0x2222), ADD with immediate 0 → o_alu = 0x1111. Dropping the mem enable gives 0x2222.
- SHL with A = 0xC000 and immd = 1 → o_alu = 0x8000, C = 1. A shift of 0 keeps the prior C.
- Stall for 3 cycles with new inputs → outputs frozen. Flush during the stall → next edge o_WB = 0 and o_Mem = 0.
- Save the CCR (0b0101), then ALU-set the CCR to 0b0000, then restore with value 0b0101 → o_saved_flag = 0101 and o_flag = 0101. Asserting rst mid-sequence → all outputs 0 immediately.
